// File: rtl/cr_seu_randclk_pkg.sv
// rtl/cr_seu_randclk_pkg.sv - shared state encoding, LFSR taps and reset seed for the randclk generator
package cr_seu_randclk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  localparam logic [31:0] LFSR_TAPS        = 32'h80200003;
  localparam logic [31:0] RST_SEED_DEFAULT = 32'hACE12468;

  // Galois right-shift step for x^32+x^22+x^2+x+1
  function automatic logic [31:0] lfsr_step(input logic [31:0] value);
    return value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
  endfunction

endpackage

// File: rtl/cr_seu_randclk_lfsr.sv
// rtl/cr_seu_randclk_lfsr.sv - 32-bit Galois LFSR with seed load taking priority over step
module cr_seu_randclk_lfsr
  import cr_seu_randclk_pkg::*;
#(
  parameter logic [31:0] RST_SEED = RST_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        step,
  output logic [31:0] value
);

  // A zero seed would lock the register at zero, so it is replaced by the reset seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= RST_SEED;
    end else if (load) begin
      value <= (load_value == 32'h0) ? RST_SEED : load_value;
    end else if (step) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/cr_seu_randclk_gen.sv
// rtl/cr_seu_randclk_gen.sv - density-controlled pseudo-random mod-enable generator for the IFU randclk block
// Optional feature: CR_SEU_RANDCLK_FORCE_EN adds randclk_force to drive cfg_bit_mask straight out.
module cr_seu_randclk_gen
  import cr_seu_randclk_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter int          DWELL    = 8,
  parameter logic [31:0] RST_SEED = RST_SEED_DEFAULT
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
`ifdef CR_SEU_RANDCLK_FORCE_EN
  input  logic             randclk_force,
`endif
  input  logic             cfg_en,
  input  logic             cfg_seed_vld,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic [7:0]       cfg_density,
  input  logic [WIDTH-1:0] cfg_bit_mask,
  output logic             seed_ack,
  output logic             randclk_busy,
  output logic [WIDTH-1:0] seu_ifu_randclk_mod_en
);

  localparam logic [3:0] DWELL_RELOAD = 4'(DWELL - 1);

  state_t     state, state_d;
  logic [3:0] dwell_cnt, dwell_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0] lfsr;

  cr_seu_randclk_lfsr #(.RST_SEED(RST_SEED)) u_lfsr (
    .clk        (forever_cpuclk),
    .rst        (cpurst),
    .load       (cfg_seed_vld),
    .load_value (cfg_seed),
    .step       (state == RUN),
    .value      (lfsr)
  );

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state     <= IDLE;
      dwell_cnt <= 4'd0;
      mask_q    <= '0;
      seed_ack  <= 1'b0;
    end else begin
      state     <= state_d;
      dwell_cnt <= dwell_d;
      mask_q    <= mask_d;
      seed_ack  <= cfg_seed_vld;
    end
  end

  // Dropping cfg_en in RUN clears the mask immediately, even mid-dwell
  always_comb begin
    state_d = state;
    dwell_d = dwell_cnt;
    mask_d  = mask_q;
    case (state)
      IDLE: begin
        mask_d = '0;
        if (cfg_en) begin
          state_d = RUN;
          dwell_d = 4'd0;
        end
      end
      RUN: begin
        if (!cfg_en) begin
          state_d = DRAIN;
          mask_d  = '0;
        end else if (dwell_cnt == 4'd0) begin
          mask_d  = (lfsr[7:0] < cfg_density) ? (lfsr & cfg_bit_mask) : '0;
          dwell_d = DWELL_RELOAD;
        end else begin
          dwell_d = dwell_cnt - 4'd1;
        end
      end
      DRAIN: begin
        mask_d  = '0;
        state_d = IDLE;
      end
      default: begin
        mask_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign randclk_busy = (state == RUN) || (state == DRAIN);

`ifdef CR_SEU_RANDCLK_FORCE_EN
  logic [WIDTH-1:0] mod_en_q;

  // The dwell mask keeps evolving underneath a force, so release returns to it directly
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      mod_en_q <= '0;
    end else begin
      mod_en_q <= randclk_force ? cfg_bit_mask : mask_d;
    end
  end

  assign seu_ifu_randclk_mod_en = mod_en_q;
`else
  assign seu_ifu_randclk_mod_en = mask_q;
`endif

endmodule

// File: tb/tb_cr_seu_randclk_gen.sv
// tb/tb_cr_seu_randclk_gen.sv - directed self-checking bench for cr_seu_randclk_gen (DWELL=1 and DWELL=8 instances)
module tb_cr_seu_randclk_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_en = 1'b0;
  logic        cfg_seed_vld = 1'b0;
  logic [31:0] cfg_seed = 32'h0;
  logic [7:0]  cfg_density = 8'h0;
  logic [31:0] cfg_bit_mask = 32'h0;
  logic        randclk_force = 1'b0;
  logic        ack1, ack8, busy1, busy8;
  logic [31:0] mod1, mod8;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  cr_seu_randclk_gen #(.DWELL(1)) dut1 (
    .forever_cpuclk         (clk),
    .cpurst                 (rst),
`ifdef CR_SEU_RANDCLK_FORCE_EN
    .randclk_force          (randclk_force),
`endif
    .cfg_en                 (cfg_en),
    .cfg_seed_vld           (cfg_seed_vld),
    .cfg_seed               (cfg_seed),
    .cfg_density            (cfg_density),
    .cfg_bit_mask           (cfg_bit_mask),
    .seed_ack               (ack1),
    .randclk_busy           (busy1),
    .seu_ifu_randclk_mod_en (mod1)
  );

  cr_seu_randclk_gen #(.DWELL(8)) dut8 (
    .forever_cpuclk         (clk),
    .cpurst                 (rst),
`ifdef CR_SEU_RANDCLK_FORCE_EN
    .randclk_force          (randclk_force),
`endif
    .cfg_en                 (cfg_en),
    .cfg_seed_vld           (cfg_seed_vld),
    .cfg_seed               (cfg_seed),
    .cfg_density            (cfg_density),
    .cfg_bit_mask           (cfg_bit_mask),
    .seed_ack               (ack8),
    .randclk_busy           (busy8),
    .seu_ifu_randclk_mod_en (mod8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_en = 1'b0;
    cfg_seed_vld = 1'b0;
    cfg_seed = 32'h0;
    cfg_density = 8'h0;
    cfg_bit_mask = 32'h0;
    randclk_force = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_seed(input logic [31:0] seed);
    cfg_seed = seed;
    cfg_seed_vld = 1'b1;
    tick();
    cfg_seed_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    compared++;
    if (mod1 !== 32'h0 || busy1 !== 1'b0 || ack1 !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got mod=%h busy=%b ack=%b expected 0/0/0", mod1, busy1, ack1);
    end
    compared++;
    if (dut1.lfsr !== 32'hACE12468) begin
      mismatched++;
      $display("FAIL reset_lfsr: got %h expected acе12468", dut1.lfsr);
    end
    do_reset();
    for (int i = 0; i < 100; i++) begin
      tick();
      compared++;
      if (mod1 !== 32'h0 || busy1 !== 1'b0 || dut1.lfsr !== 32'hACE12468) begin
        mismatched++;
        $display("FAIL idle_hold[%0d]: got mod=%h busy=%b lfsr=%h expected 0/0/ace12468", i, mod1, busy1, dut1.lfsr);
      end
    end
  endtask

  task automatic test_first_masks();
    logic [31:0] exp_seq [5];
    exp_seq = '{32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001, 32'hB02C0003};
    do_reset();
    load_seed(32'h1);
    compared++;
    if (dut1.lfsr !== 32'h1 || ack1 !== 1'b1) begin
      mismatched++;
      $display("FAIL seed_load: got lfsr=%h ack=%b expected 00000001/1", dut1.lfsr, ack1);
    end
    cfg_density = 8'd255;
    cfg_bit_mask = 32'hFFFFFFFF;
    cfg_en = 1'b1;
    tick();
    compared++;
    if (busy1 !== 1'b1 || mod1 !== 32'h0 || ack1 !== 1'b0) begin
      mismatched++;
      $display("FAIL run_entry: got busy=%b mod=%h ack=%b expected 1/0/0", busy1, mod1, ack1);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if (mod1 !== exp_seq[i]) begin
        mismatched++;
        $display("FAIL mask_seq[%0d]: got %h expected %h", i, mod1, exp_seq[i]);
      end
    end
  endtask

  task automatic test_density_zero();
    do_reset();
    cfg_density = 8'd0;
    cfg_bit_mask = 32'hFFFFFFFF;
    cfg_en = 1'b1;
    tick();
    for (int i = 0; i < 1000; i++) begin
      tick();
      compared++;
      if (mod1 !== 32'h0 || mod8 !== 32'h0 || busy1 !== 1'b1) begin
        mismatched++;
        $display("FAIL density_zero[%0d]: got mod1=%h mod8=%h busy=%b expected 0/0/1", i, mod1, mod8, busy1);
      end
    end
  endtask

  task automatic test_density_boundary();
    do_reset();
    load_seed(32'h10);
    cfg_density = 8'h10;
    cfg_bit_mask = 32'hFFFFFFFF;
    cfg_en = 1'b1;
    tick();
    tick();
    compared++;
    if (mod1 !== 32'h0) begin
      mismatched++;
      $display("FAIL density_equal: got %h expected 00000000", mod1);
    end
    tick();
    compared++;
    if (mod1 !== 32'h8) begin
      mismatched++;
      $display("FAIL density_below: got %h expected 00000008", mod1);
    end
  endtask

  task automatic test_dwell_window();
    do_reset();
    load_seed(32'h1);
    cfg_density = 8'd255;
    cfg_bit_mask = 32'hFFFFFFFF;
    cfg_en = 1'b1;
    tick();
    tick();
    compared++;
    if (mod8 !== 32'h1) begin
      mismatched++;
      $display("FAIL dwell_first: got %h expected 00000001", mod8);
    end
    cfg_bit_mask = 32'h0000FFFF;
    for (int i = 0; i < 7; i++) begin
      tick();
      compared++;
      if (mod8 !== 32'h1) begin
        mismatched++;
        $display("FAIL dwell_hold[%0d]: got %h expected 00000001", i, mod8);
      end
    end
    tick();
    compared++;
    if (mod8 !== 32'h0000C002) begin
      mismatched++;
      $display("FAIL dwell_second: got %h expected 0000c002", mod8);
    end
  endtask

  task automatic test_dwell_abort();
    do_reset();
    load_seed(32'h1);
    cfg_density = 8'd255;
    cfg_bit_mask = 32'hFFFFFFFF;
    cfg_en = 1'b1;
    tick();
    tick();
    tick();
    tick();
    compared++;
    if (dut8.dwell_cnt !== 4'd5 || mod8 !== 32'h1) begin
      mismatched++;
      $display("FAIL abort_setup: got dwell=%0d mod=%h expected 5/00000001", dut8.dwell_cnt, mod8);
    end
    cfg_en = 1'b0;
    tick();
    compared++;
    if (mod8 !== 32'h0 || busy8 !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_drain: got mod=%h busy=%b expected 0/1", mod8, busy8);
    end
    tick();
    compared++;
    if (mod8 !== 32'h0 || busy8 !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_idle: got mod=%h busy=%b expected 0/0", mod8, busy8);
    end
  endtask

  task automatic test_seed_zero();
    do_reset();
    load_seed(32'h1);
    cfg_density = 8'd255;
    cfg_bit_mask = 32'hFFFFFFFF;
    cfg_en = 1'b1;
    tick();
    tick();
    cfg_seed = 32'h0;
    cfg_seed_vld = 1'b1;
    tick();
    cfg_seed_vld = 1'b0;
    compared++;
    if (dut1.lfsr !== 32'hACE12468 || ack1 !== 1'b1) begin
      mismatched++;
      $display("FAIL zero_seed_load: got lfsr=%h ack=%b expected ace12468/1", dut1.lfsr, ack1);
    end
    tick();
    compared++;
    if (dut1.lfsr !== 32'h56709234 || ack1 !== 1'b0 || busy1 !== 1'b1) begin
      mismatched++;
      $display("FAIL zero_seed_step: got lfsr=%h ack=%b busy=%b expected 56709234/0/1", dut1.lfsr, ack1, busy1);
    end
  endtask

  task automatic test_back_to_back();
    cfg_seed = 32'h5;
    cfg_seed_vld = 1'b1;
    tick();
    compared++;
    if (dut1.lfsr !== 32'h5 || ack1 !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_first: got lfsr=%h ack=%b expected 00000005/1", dut1.lfsr, ack1);
    end
    cfg_seed = 32'h7;
    tick();
    cfg_seed_vld = 1'b0;
    compared++;
    if (dut1.lfsr !== 32'h7 || ack1 !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_second: got lfsr=%h ack=%b expected 00000007/1", dut1.lfsr, ack1);
    end
    tick();
    compared++;
    if (dut1.lfsr !== 32'h80200000 || ack1 !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_after: got lfsr=%h ack=%b expected 80200000/0", dut1.lfsr, ack1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    load_seed(32'h1);
    cfg_density = 8'd255;
    cfg_bit_mask = 32'hFFFFFFFF;
    cfg_en = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (mod1 !== 32'h0 || busy1 !== 1'b0 || dut1.lfsr !== 32'hACE12468) begin
      mismatched++;
      $display("FAIL async_reset: got mod=%h busy=%b lfsr=%h expected 0/0/ace12468", mod1, busy1, dut1.lfsr);
    end
    do_reset();
  endtask

`ifdef CR_SEU_RANDCLK_FORCE_EN
  task automatic test_force();
    do_reset();
    cfg_bit_mask = 32'hF;
    randclk_force = 1'b1;
    tick();
    compared++;
    if (mod1 !== 32'hF) begin
      mismatched++;
      $display("FAIL force_on: got %h expected 0000000f", mod1);
    end
    randclk_force = 1'b0;
    tick();
    compared++;
    if (mod1 !== 32'h0) begin
      mismatched++;
      $display("FAIL force_release: got %h expected 00000000", mod1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_masks();
    test_density_zero();
    test_density_boundary();
    test_dwell_window();
    test_dwell_abort();
    test_seed_zero();
    test_back_to_back();
    test_async_reset();
`ifdef CR_SEU_RANDCLK_FORCE_EN
    test_force();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
